// File: rtl/pp_rf_sb_if.sv
// Issue/writeback/read bundle between the issue stage and the register file with scoreboard.
// The master side drives addresses, write data and issue info; the slave side returns read data and busy state.
interface pp_rf_sb_if #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned AW   = 5
);
    logic [AW-1:0]   rs1;
    logic [AW-1:0]   rs2;
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] writedata;
    logic            regwrite;
    logic            iss_valid;
    logic [AW-1:0]   iss_rd;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic            busy1;
    logic            busy2;
    logic [AW:0]     busy_cnt;

    modport master (
        output rs1, rs2, rd, writedata, regwrite, iss_valid, iss_rd,
        input  rd1, rd2, busy1, busy2, busy_cnt
    );

    modport slave (
        input  rs1, rs2, rd, writedata, regwrite, iss_valid, iss_rd,
        output rd1, rd2, busy1, busy2, busy_cnt
    );
endinterface

// File: rtl/pp_rf_sb.sv
// Two-read/one-write register file with registered, bypassed reads and a per-register
// pending (busy) scoreboard that is set on issue and cleared on writeback.
module pp_rf_sb #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned AW       = 5,
    parameter bit          ZERO_REG = 1'b1,
    parameter bit          INIT_IDX = 1'b1
) (
    input  logic      clk,
    input  logic      rst_n,
    pp_rf_sb_if.slave bus
);
    localparam int unsigned NREG = 2 ** AW;
    localparam int unsigned CW   = AW + 1;

    logic [XLEN-1:0] rf [NREG];
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_next_c;
    logic [CW-1:0]   busy_cnt_q;
    logic [CW-1:0]   busy_cnt_next_c;
    logic [XLEN-1:0] rd1_q;
    logic [XLEN-1:0] rd2_q;
    logic            busy1_q;
    logic            busy2_q;

    logic            wr_en_c;
    logic            iss_en_c;
    logic            cnt_inc_c;
    logic            cnt_dec_c;
    logic [XLEN-1:0] rd1_next_c;
    logic [XLEN-1:0] rd2_next_c;

    // Register 0 swallows writes and issues when it is hardwired
    always_comb begin
        wr_en_c  = bus.regwrite  && !(ZERO_REG && (bus.rd == '0));
        iss_en_c = bus.iss_valid && !(ZERO_REG && (bus.iss_rd == '0));
    end

    // Clear first, then set, so a same-edge issue leaves the new producer pending
    always_comb begin
        busy_next_c = busy_q;
        if (bus.regwrite) begin
            busy_next_c[bus.rd] = 1'b0;
        end
        if (iss_en_c) begin
            busy_next_c[bus.iss_rd] = 1'b1;
        end
    end

    // Incremental population count; a clear of an idle register changes nothing
    always_comb begin
        cnt_inc_c       = iss_en_c && !busy_q[bus.iss_rd];
        cnt_dec_c       = bus.regwrite && busy_q[bus.rd]
                          && !(iss_en_c && (bus.iss_rd == bus.rd));
        busy_cnt_next_c = busy_cnt_q + CW'(cnt_inc_c) - CW'(cnt_dec_c);
    end

    // Read muxes: hardwired zero, then same-edge write bypass, then array
    always_comb begin
        rd1_next_c = rf[bus.rs1];
        rd2_next_c = rf[bus.rs2];
        if (wr_en_c && (bus.rd == bus.rs1)) begin
            rd1_next_c = bus.writedata;
        end
        if (wr_en_c && (bus.rd == bus.rs2)) begin
            rd2_next_c = bus.writedata;
        end
        if (ZERO_REG && (bus.rs1 == '0)) begin
            rd1_next_c = '0;
        end
        if (ZERO_REG && (bus.rs2 == '0)) begin
            rd2_next_c = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                rf[i] <= INIT_IDX ? XLEN'(i) : '0;
            end
        end else if (wr_en_c) begin
            rf[bus.rd] <= bus.writedata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q     <= '0;
            busy_cnt_q <= '0;
            rd1_q      <= '0;
            rd2_q      <= '0;
            busy1_q    <= 1'b0;
            busy2_q    <= 1'b0;
        end else begin
            busy_q     <= busy_next_c;
            busy_cnt_q <= busy_cnt_next_c;
            rd1_q      <= rd1_next_c;
            rd2_q      <= rd2_next_c;
            busy1_q    <= busy_next_c[bus.rs1];
            busy2_q    <= busy_next_c[bus.rs2];
        end
    end

    assign bus.rd1      = rd1_q;
    assign bus.rd2      = rd2_q;
    assign bus.busy1    = busy1_q;
    assign bus.busy2    = busy2_q;
    assign bus.busy_cnt = busy_cnt_q;
endmodule

// File: tb/tb_pp_rf_sb.sv
// Bench for pp_rf_sb: array/bitmap reference model compared every cycle, plus
// literal expectations for the reset, zero-register, bypass and scoreboard scenarios.
module tb_pp_rf_sb;
    localparam int unsigned XLEN     = 32;
    localparam int unsigned AW       = 5;
    localparam int unsigned NREG     = 2 ** AW;
    localparam bit          ZERO_REG = 1'b1;
    localparam bit          INIT_IDX = 1'b1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic chk_en = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    pp_rf_sb_if #(.XLEN(XLEN), .AW(AW)) bus ();

    pp_rf_sb #(
        .XLEN(XLEN), .AW(AW), .ZERO_REG(ZERO_REG), .INIT_IDX(INIT_IDX)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Reference state: plain array of values and a bitmap of pending registers
    logic [XLEN-1:0] m_rf [NREG];
    logic [NREG-1:0] m_busy;
    logic [XLEN-1:0] e_rd1, e_rd2;
    logic            e_busy1, e_busy2;
    logic [AW:0]     e_cnt;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) begin
            m_rf[i] = INIT_IDX ? XLEN'(i) : '0;
        end
        m_busy  = '0;
        e_rd1   = '0;
        e_rd2   = '0;
        e_busy1 = 1'b0;
        e_busy2 = 1'b0;
        e_cnt   = '0;
    endtask

    // Model: apply writeback, then issue, then read the resulting state
    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_reset();
            end else begin
                if (bus.regwrite && !(ZERO_REG && bus.rd == 0)) m_rf[bus.rd] = bus.writedata;
                if (bus.regwrite) m_busy[bus.rd] = 1'b0;
                if (bus.iss_valid && !(ZERO_REG && bus.iss_rd == 0)) m_busy[bus.iss_rd] = 1'b1;
                e_rd1   = (ZERO_REG && bus.rs1 == 0) ? '0 : m_rf[bus.rs1];
                e_rd2   = (ZERO_REG && bus.rs2 == 0) ? '0 : m_rf[bus.rs2];
                e_busy1 = m_busy[bus.rs1];
                e_busy2 = m_busy[bus.rs2];
                e_cnt   = (AW + 1)'($countones(m_busy));
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en && rst_n) begin
                check("cyc_rd1",   64'(bus.rd1),      64'(e_rd1));
                check("cyc_rd2",   64'(bus.rd2),      64'(e_rd2));
                check("cyc_busy1", 64'(bus.busy1),    64'(e_busy1));
                check("cyc_busy2", 64'(bus.busy2),    64'(e_busy2));
                check("cyc_cnt",   64'(bus.busy_cnt), 64'(e_cnt));
            end
        end
    end

    task automatic drive(input int rs1, input int rs2, input int rd, input logic [XLEN-1:0] wd,
                         input bit we, input bit iv, input int ird);
        bus.rs1       = AW'(rs1);
        bus.rs2       = AW'(rs2);
        bus.rd        = AW'(rd);
        bus.writedata = wd;
        bus.regwrite  = we;
        bus.iss_valid = iv;
        bus.iss_rd    = AW'(ird);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(0, 0, 0, '0, 0, 0, 0);
        tick();
        check("rst_rd1", 64'(bus.rd1), 64'h0);
        check("rst_cnt", 64'(bus.busy_cnt), 64'h0);

        // Reset values with INIT_IDX
        drive(7, 31, 0, '0, 0, 0, 0);
        #5 rst_n = 1'b1;
        chk_en = 1'b1;
        tick();
        check("init_rd1", 64'(bus.rd1), 64'd7);
        check("init_rd2", 64'(bus.rd2), 64'd31);
        check("init_busy", 64'({bus.busy1, bus.busy2}), 64'h0);
        check("init_cnt", 64'(bus.busy_cnt), 64'h0);

        // Register 0 ignores writes and issues
        drive(0, 7, 0, 32'hDEADBEEF, 1, 0, 0);
        tick();
        check("zero_rd1_a", 64'(bus.rd1), 64'h0);
        drive(0, 7, 0, '0, 0, 0, 0);
        tick();
        check("zero_rd1_b", 64'(bus.rd1), 64'h0);
        drive(0, 0, 0, '0, 0, 1, 0);
        tick();
        check("zero_iss_cnt", 64'(bus.busy_cnt), 64'h0);

        // Same-edge write bypass, then the stored value
        drive(5, 5, 5, 32'h1234, 1, 0, 0);
        tick();
        check("byp_rd1", 64'(bus.rd1), 64'h1234);
        check("byp_rd2", 64'(bus.rd2), 64'h1234);
        drive(5, 5, 0, '0, 0, 0, 0);
        tick();
        check("store_rd1", 64'(bus.rd1), 64'h1234);

        // Scoreboard set/clear sequence
        drive(0, 0, 0, '0, 0, 1, 3);
        tick();
        check("sb_cnt1", 64'(bus.busy_cnt), 64'd1);
        drive(0, 0, 0, '0, 0, 1, 9);
        tick();
        check("sb_cnt2", 64'(bus.busy_cnt), 64'd2);
        drive(3, 9, 0, '0, 0, 0, 0);
        tick();
        check("sb_busy1", 64'(bus.busy1), 64'd1);
        drive(3, 9, 3, 32'h33, 1, 0, 0);
        tick();
        check("sb_wb_busy1", 64'(bus.busy1), 64'd0);
        check("sb_wb_cnt", 64'(bus.busy_cnt), 64'd1);
        tick();
        check("sb_wb2_cnt", 64'(bus.busy_cnt), 64'd1);

        // Same-edge issue and writeback on a busy register
        drive(0, 0, 0, '0, 0, 1, 4);
        tick();
        check("sc_pre_cnt", 64'(bus.busy_cnt), 64'd2);
        drive(4, 0, 4, 32'h55, 1, 1, 4);
        tick();
        check("sc_rd1", 64'(bus.rd1), 64'h55);
        check("sc_busy1", 64'(bus.busy1), 64'd1);
        check("sc_cnt", 64'(bus.busy_cnt), 64'd2);
        check("model_rf4", 64'(m_rf[4]), 64'h55);

        // Asynchronous reset between edges
        drive(5, 4, 0, '0, 0, 1, 10);
        tick();
        check("pre_rst_cnt", 64'(bus.busy_cnt), 64'd3);
        check("pre_rst_rd1", 64'(bus.rd1), 64'h1234);
        #1 rst_n = 1'b0;
        #1;
        check("arst_rd1", 64'(bus.rd1), 64'h0);
        check("arst_cnt", 64'(bus.busy_cnt), 64'h0);
        check("arst_busy", 64'({bus.busy1, bus.busy2}), 64'h0);
        #1 rst_n = 1'b1;

        // First edge after release is an ordinary cycle
        drive(6, 5, 6, 32'hABC, 1, 1, 6);
        tick();
        check("post_rd1", 64'(bus.rd1), 64'hABC);
        check("post_rd2", 64'(bus.rd2), 64'd5);
        check("post_busy1", 64'(bus.busy1), 64'd1);
        check("post_cnt", 64'(bus.busy_cnt), 64'd1);

        // Mixed traffic table checked by the model only
        for (int i = 0; i < 24; i++) begin
            drive((i * 5) % 32, (i * 11 + 3) % 32, (i * 3) % 32, 32'hA000_0000 + XLEN'(i),
                  (i % 3) != 2, (i % 2) == 0, (i * 7 + 1) % 32);
            tick();
        end
        drive(1, 2, 0, '0, 0, 0, 0);
        tick();
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/pp_rf_sb.md
# pp_rf_sb

Parametrised register file with a built-in busy scoreboard for the pipelined core. It has two read ports and one write port. Reads are registered with write-to-read bypass, and register 0 can be hardwired to zero. A per-register pending bit is set on instruction issue and cleared on writeback, so the hazard unit can stall on it. It sits between decode/issue and writeback, in place of the fixed 32x32 file.

## Interface
- XLEN, 32: data width in bits.
- AW, 5: register address width; NREG = 2**AW registers.
- ZERO_REG, 1: 1 = register 0 reads as 0 and ignores writes and issues; 0 = register 0 is ordinary.
- INIT_IDX, 1: reset value of register i. 1 = i (truncated to XLEN); 0 = 0.

- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rs1, rs2  in  AW  read addresses.
- rd  in  AW  writeback address.
- writedata  in  XLEN  writeback data.
- regwrite  in  1  writeback enable.
- iss_valid  in  1  instruction issued this cycle with a destination.
- iss_rd  in  AW  destination of the issued instruction.
- rd1, rd2  out  XLEN  registered read data.
- busy1, busy2  out  1  registered pending flag for rs1 and rs2.
- busy_cnt  out  AW+1  number of registers currently pending.

## Operation
- Reset (asynchronous, while rst_n=0):
  - rf[i] = INIT_IDX ? i : 0.
  - All busy bits = 0; busy_cnt = 0.
  - rd1 = rd2 = 0; busy1 = busy2 = 0.
- Write: on a rising edge with regwrite=1, rf[rd] <= writedata. Ignored when rd=0 and ZERO_REG=1.
- Read (each rising edge, port n = 1, 2):
  - rdn <= 0 if rsn=0 and ZERO_REG=1.
  - Else rdn <= writedata if the write is effective this cycle and rd == rsn (bypass).
  - Else rdn <= rf[rsn].
- Scoreboard next state, per register r:
  - set_r = iss_valid & (iss_rd == r).
  - clr_r = regwrite & (rd == r).
  - busy_next[r] = set_r | (busy[r] & ~clr_r). Set wins over clear: the new producer is pending.
  - With ZERO_REG=1, register 0 is never set; busy[0] stays 0.
- busyn <= busy_next[rsn], using the post-update value, so it is consistent with the bypassed data.
- busy_cnt tracks the population count of busy, updated incrementally:
  - +1 when set hits a non-busy register.
  - −1 when clear hits a busy register with no same-register set.
  - Otherwise unchanged.
  - Never exceeds NREG and never underflows; a clear of a non-busy register is a no-op.
- Simultaneous write and issue to the same register: data is written, the register becomes (stays) busy, busy_cnt is unchanged if it was busy, and +1 if it was not.

## Timing
- Read latency: 1 cycle. Addresses presented before edge k give data and busy after edge k.
- Write-to-read: same edge via bypass; no dead cycle.
- Issue-to-busy: a set at edge k is visible on busyn after edge k when rsn == iss_rd.
- Writeback-to-not-busy: same edge, unless overridden by a same-edge set.
- busy_cnt reflects the state after each edge; its latency equals the busy bit latency.
- Reset asserted mid-operation: all outputs go to their reset values immediately, without waiting for clk. The first edge after rst_n rises behaves as a normal cycle.
- No combinational path from inputs to outputs.

## Test plan
- Reset, INIT_IDX=1: release rst_n, then read rs1=7, rs2=31 -> rd1=7, rd2=31, busy1=busy2=0, busy_cnt=0.
- Zero register, ZERO_REG=1: regwrite rd=0, writedata=0xDEADBEEF with rs1=0 on the same edge; next edge rs1=0 -> rd1=0 both cycles. Issue to rd 0 -> busy_cnt stays 0.
- Bypass: regwrite rd=5, writedata=0x1234, rs1=rs2=5 on the same edge -> rd1=rd2=0x1234 after that edge. The following cycle, with regwrite=0 -> still 0x1234.
- Scoreboard:
  - Issue rd=3, then issue rd=9 -> busy_cnt=1, then 2.
  - Read rs1=3 -> busy1=1.
  - Writeback rd=3 -> busy1=0, busy_cnt=1.
  - Writeback rd=3 again -> busy_cnt stays 1.
- Same-edge set and clear: register 4 busy; issue rd=4 with regwrite rd=4, writedata=0x55 on one edge -> rf[4]=0x55, busy[4]=1, busy_cnt unchanged.
- Async reset mid-operation: with 3 registers busy and rd1 nonzero, pulse rst_n low between edges -> rd1=0, busy_cnt=0 immediately. rf[i] returns to i.
